// File: rtl/pipe_run_ctrl.sv
// Run/halt/step sequencer with next-PC breakpoint and enabled-cycle counter.
// Define PIPE_RETIRE_CNT_EN to build the retired-instruction counter; otherwise retire_cnt is 0.
module pipe_run_ctrl #(
   parameter int unsigned CNT_W        = 32,
   parameter int unsigned STEP_W       = 16,
   parameter bit          RUN_ON_RESET = 1'b0
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [1:0]        cmd,
   input  logic [STEP_W-1:0] step_n,
   input  logic              bp_en,
   input  logic [31:0]       bp_addr,
   input  logic [31:0]       npc,
   input  logic [31:0]       wb_ir,
   output logic              cpu_en,
   output logic              halted,
   output logic              bp_hit,
   output logic              step_done,
   output logic [CNT_W-1:0]  cycle_cnt,
   output logic [CNT_W-1:0]  retire_cnt
);

   typedef enum logic [1:0] {ST_HALT, ST_RUN, ST_STEP, ST_BREAK} state_t;
   typedef enum logic [1:0] {
      CMD_HALT  = 2'b00,
      CMD_RUN   = 2'b01,
      CMD_STEP  = 2'b10,
      CMD_CLEAR = 2'b11
   } cmd_t;

   localparam state_t RST_STATE = RUN_ON_RESET ? ST_RUN : ST_HALT;

   state_t            state_q, state_d;
   logic [STEP_W-1:0] rem_q, rem_d;
   logic              cpu_en_q;
   logic              done_q, done_d;
   logic              clr;
   logic              cmd_acc;
   logic              bp_cond;
   cmd_t              cmd_c;
   logic [CNT_W-1:0]  cycle_q;

   assign cmd_c     = cmd_t'(cmd);
   assign cmd_ready = (state_q != ST_STEP);
   assign cmd_acc   = cmd_valid && cmd_ready;
   assign bp_cond   = cpu_en_q && bp_en && (npc == bp_addr);

   always_comb begin
      state_d = state_q;
      rem_d   = rem_q;
      done_d  = 1'b0;
      clr     = 1'b0;
      if (state_q == ST_STEP) begin
         // Commands are ignored while stepping; a breakpoint ends the step early.
         rem_d = rem_q - STEP_W'(1);
         if (bp_cond) begin
            state_d = ST_BREAK;
            done_d  = 1'b1;
         end else if (rem_q == STEP_W'(1)) begin
            state_d = ST_HALT;
            done_d  = 1'b1;
         end
      end else begin
         if (cmd_acc) begin
            case (cmd_c)
               CMD_HALT:  state_d = ST_HALT;
               CMD_RUN:   state_d = ST_RUN;
               CMD_STEP: begin
                  if (state_q != ST_RUN) begin
                     state_d = ST_STEP;
                     rem_d   = (step_n == '0) ? STEP_W'(1) : step_n;
                  end
               end
               CMD_CLEAR: clr = 1'b1;
               default:   state_d = state_q;
            endcase
         end
         if (bp_cond)
            state_d = ST_BREAK;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q  <= RST_STATE;
         rem_q    <= '0;
         cpu_en_q <= RUN_ON_RESET;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         rem_q    <= rem_d;
         cpu_en_q <= (state_d == ST_RUN) || (state_d == ST_STEP);
         done_q   <= done_d;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn)
         cycle_q <= '0;
      else if (clr)
         cycle_q <= '0;
      else if (cpu_en_q)
         cycle_q <= cycle_q + CNT_W'(1);
   end

`ifdef PIPE_RETIRE_CNT_EN
   logic [CNT_W-1:0] retire_q;
   logic             real_insn;

   // Flushed bubbles (all zero) and canonical nops do not count as retired.
   assign real_insn = (wb_ir != 32'h0000_0000) && (wb_ir != 32'h0000_0013);

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn)
         retire_q <= '0;
      else if (clr)
         retire_q <= '0;
      else if (cpu_en_q && real_insn)
         retire_q <= retire_q + CNT_W'(1);
   end

   assign retire_cnt = retire_q;
`else
   logic unused_wb_ir;
   assign unused_wb_ir = ^wb_ir;
   assign retire_cnt   = '0;
`endif

   assign cpu_en    = cpu_en_q;
   assign halted    = (state_q == ST_HALT) || (state_q == ST_BREAK);
   assign bp_hit    = (state_q == ST_BREAK);
   assign step_done = done_q;
   assign cycle_cnt = cycle_q;

endmodule

// File: tb/tb_pipe_run_ctrl.sv
// Self-checking bench for pipe_run_ctrl: per-scenario tasks with arithmetic expectations
// and a straight-line program counter model feeding npc.
module tb_pipe_run_ctrl;

   localparam logic [1:0] C_HALT  = 2'b00;
   localparam logic [1:0] C_RUN   = 2'b01;
   localparam logic [1:0] C_STEP  = 2'b10;
   localparam logic [1:0] C_CLEAR = 2'b11;

   logic        clk = 1'b0;
   logic        rstn;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [1:0]  cmd;
   logic [15:0] step_n;
   logic        bp_en;
   logic [31:0] bp_addr;
   logic [31:0] npc;
   logic [31:0] wb_ir;
   logic        cpu_en;
   logic        halted;
   logic        bp_hit;
   logic        step_done;
   logic [31:0] cycle_cnt;
   logic [31:0] retire_cnt;

   logic [31:0] pc;
   logic        pc_load;
   logic [31:0] pc_load_val;

   int unsigned n_checks = 0;
   int unsigned n_errors = 0;
   int unsigned exp_cyc  = 0;

   pipe_run_ctrl #(.CNT_W(32), .STEP_W(16), .RUN_ON_RESET(1'b0)) dut (
      .clk(clk), .rstn(rstn), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd(cmd), .step_n(step_n), .bp_en(bp_en), .bp_addr(bp_addr),
      .npc(npc), .wb_ir(wb_ir), .cpu_en(cpu_en), .halted(halted),
      .bp_hit(bp_hit), .step_done(step_done), .cycle_cnt(cycle_cnt),
      .retire_cnt(retire_cnt)
   );

   always #5 clk = ~clk;

   // Straight-line program: IF_pc advances by 4 on every enabled edge.
   assign npc = pc + 32'd4;
   always @(posedge clk) begin
      if (pc_load)
         pc <= pc_load_val;
      else if (cpu_en)
         pc <= npc;
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [1:0] c, input logic [15:0] n);
      cmd       = c;
      step_n    = n;
      cmd_valid = 1'b1;
      tick();
      cmd_valid = 1'b0;
   endtask

   task automatic load_pc(input logic [31:0] a);
      pc_load_val = a;
      pc_load     = 1'b1;
      tick();
      pc_load     = 1'b0;
   endtask

   task automatic test_reset;
      rstn = 1'b0;
      repeat (2) tick();
      n_checks++; if (cpu_en !== 1'b0) begin n_errors++; $display("FAIL rst_cpu_en got %b exp 0", cpu_en); end
      n_checks++; if (halted !== 1'b1) begin n_errors++; $display("FAIL rst_halted got %b exp 1", halted); end
      n_checks++; if (bp_hit !== 1'b0) begin n_errors++; $display("FAIL rst_bp_hit got %b exp 0", bp_hit); end
      n_checks++; if (step_done !== 1'b0) begin n_errors++; $display("FAIL rst_step_done got %b exp 0", step_done); end
      n_checks++; if (cycle_cnt !== 32'd0) begin n_errors++; $display("FAIL rst_cycle_cnt got %0d exp 0", cycle_cnt); end
      n_checks++; if (retire_cnt !== 32'd0) begin n_errors++; $display("FAIL rst_retire_cnt got %0d exp 0", retire_cnt); end
      n_checks++; if (cmd_ready !== 1'b1) begin n_errors++; $display("FAIL rst_cmd_ready got %b exp 1", cmd_ready); end
      rstn = 1'b1;
      repeat (3) tick();
      n_checks++; if (cpu_en !== 1'b0) begin n_errors++; $display("FAIL post_rst_cpu_en got %b exp 0", cpu_en); end
      exp_cyc = 0;
   endtask

   task automatic test_run_halt;
      for (int i = 0; i < 3; i++) begin
         int unsigned n;
         n = (i == 0) ? 10 : $urandom_range(3, 20);
         issue(C_RUN, 16'd0);
         n_checks++; if (cpu_en !== 1'b1) begin n_errors++; $display("FAIL run_cpu_en got %b exp 1", cpu_en); end
         repeat (n - 1) tick();
         issue(C_HALT, 16'd0);
         exp_cyc += n;
         n_checks++; if (cpu_en !== 1'b0) begin n_errors++; $display("FAIL halt_cpu_en got %b exp 0", cpu_en); end
         n_checks++; if (halted !== 1'b1) begin n_errors++; $display("FAIL halt_halted got %b exp 1", halted); end
         n_checks++; if (cycle_cnt !== exp_cyc) begin n_errors++; $display("FAIL run_cycle_cnt got %0d exp %0d", cycle_cnt, exp_cyc); end
      end
   endtask

   task automatic test_step(input logic [15:0] n_in);
      int unsigned n;
      n = (n_in == 16'd0) ? 1 : int'(n_in);
      issue(C_STEP, n_in);
      for (int unsigned c = 1; c <= n + 2; c++) begin
         n_checks++; if (cpu_en !== (c <= n)) begin n_errors++; $display("FAIL step_cpu_en n=%0d c=%0d got %b exp %b", n, c, cpu_en, (c <= n)); end
         n_checks++; if (step_done !== (c == n + 1)) begin n_errors++; $display("FAIL step_done n=%0d c=%0d got %b exp %b", n, c, step_done, (c == n + 1)); end
         n_checks++; if (cmd_ready !== (c > n)) begin n_errors++; $display("FAIL step_cmd_ready n=%0d c=%0d got %b exp %b", n, c, cmd_ready, (c > n)); end
         n_checks++; if (halted !== (c > n)) begin n_errors++; $display("FAIL step_halted n=%0d c=%0d got %b exp %b", n, c, halted, (c > n)); end
         // Stray HALT requests while stepping must be ignored.
         cmd       = C_HALT;
         cmd_valid = (c <= n) ? 1'($urandom_range(0, 1)) : 1'b0;
         tick();
      end
      cmd_valid = 1'b0;
      exp_cyc += n;
      n_checks++; if (cycle_cnt !== exp_cyc) begin n_errors++; $display("FAIL step_cycle_cnt got %0d exp %0d", cycle_cnt, exp_cyc); end
   endtask

   task automatic test_breakpoint(input int unsigned k);
      issue(C_CLEAR, 16'd0);
      exp_cyc = 0;
      n_checks++; if (cycle_cnt !== 32'd0) begin n_errors++; $display("FAIL bp_clear got %0d exp 0", cycle_cnt); end
      load_pc(32'd0);
      bp_addr = 32'(4 * k);
      bp_en   = 1'b1;
      issue(C_RUN, 16'd0);
      for (int unsigned c = 1; c <= k + 2; c++) begin
         n_checks++; if (cpu_en !== (c <= k)) begin n_errors++; $display("FAIL bp_cpu_en k=%0d c=%0d got %b exp %b", k, c, cpu_en, (c <= k)); end
         n_checks++; if (bp_hit !== (c > k)) begin n_errors++; $display("FAIL bp_hit k=%0d c=%0d got %b exp %b", k, c, bp_hit, (c > k)); end
         tick();
      end
      exp_cyc += k;
      n_checks++; if (cycle_cnt !== exp_cyc) begin n_errors++; $display("FAIL bp_cycle_cnt got %0d exp %0d", cycle_cnt, exp_cyc); end
      n_checks++; if (pc !== bp_addr) begin n_errors++; $display("FAIL bp_pc got %h exp %h", pc, bp_addr); end
      n_checks++; if (halted !== 1'b1) begin n_errors++; $display("FAIL bp_halted got %b exp 1", halted); end
      issue(C_RUN, 16'd0);
      n_checks++; if (cpu_en !== 1'b1) begin n_errors++; $display("FAIL bp_resume_en got %b exp 1", cpu_en); end
      tick();
      n_checks++; if (bp_hit !== 1'b0) begin n_errors++; $display("FAIL bp_rebreak got %b exp 0", bp_hit); end
      n_checks++; if (cpu_en !== 1'b1) begin n_errors++; $display("FAIL bp_resume_en2 got %b exp 1", cpu_en); end
      issue(C_HALT, 16'd0);
      exp_cyc += 2;
      bp_en = 1'b0;
      n_checks++; if (cycle_cnt !== exp_cyc) begin n_errors++; $display("FAIL bp_resume_cnt got %0d exp %0d", cycle_cnt, exp_cyc); end
   endtask

   task automatic test_step_bp(input int unsigned n, input int unsigned b);
      logic [31:0] p;
      p = 32'h100 + 32'(4 * $urandom_range(0, 100));
      load_pc(p);
      bp_addr = p + 32'(4 * b);
      bp_en   = 1'b1;
      issue(C_STEP, 16'(n));
      for (int unsigned c = 1; c <= b + 2; c++) begin
         n_checks++; if (cpu_en !== (c <= b)) begin n_errors++; $display("FAIL sbp_cpu_en n=%0d b=%0d c=%0d got %b exp %b", n, b, c, cpu_en, (c <= b)); end
         n_checks++; if (step_done !== (c == b + 1)) begin n_errors++; $display("FAIL sbp_step_done n=%0d b=%0d c=%0d got %b exp %b", n, b, c, step_done, (c == b + 1)); end
         n_checks++; if (bp_hit !== (c > b)) begin n_errors++; $display("FAIL sbp_bp_hit n=%0d b=%0d c=%0d got %b exp %b", n, b, c, bp_hit, (c > b)); end
         tick();
      end
      exp_cyc += b;
      n_checks++; if (cycle_cnt !== exp_cyc) begin n_errors++; $display("FAIL sbp_cycle_cnt got %0d exp %0d", cycle_cnt, exp_cyc); end
      bp_en = 1'b0;
      issue(C_HALT, 16'd0);
      n_checks++; if (bp_hit !== 1'b0) begin n_errors++; $display("FAIL sbp_halt_bp_hit got %b exp 0", bp_hit); end
   endtask

   task automatic test_clear;
      logic [31:0] seq [6];
      int unsigned bub0, bub1, exp_ret;
      issue(C_RUN, 16'd0);
      repeat ($urandom_range(2, 8)) tick();
      issue(C_CLEAR, 16'd0);
      n_checks++; if (cycle_cnt !== 32'd0) begin n_errors++; $display("FAIL clr_cycle_cnt got %0d exp 0", cycle_cnt); end
      n_checks++; if (retire_cnt !== 32'd0) begin n_errors++; $display("FAIL clr_retire_cnt got %0d exp 0", retire_cnt); end
      n_checks++; if (cpu_en !== 1'b1) begin n_errors++; $display("FAIL clr_cpu_en got %b exp 1", cpu_en); end
      bub0 = $urandom_range(0, 5);
      bub1 = (bub0 + 1 + $urandom_range(0, 4)) % 6;
      exp_ret = 0;
      for (int unsigned i = 0; i < 6; i++) begin
         if (i == bub0 || i == bub1)
            seq[i] = $urandom_range(0, 1) ? 32'h0000_0013 : 32'h0000_0000;
         else
            seq[i] = $urandom | 32'h1000_0000;
         if (seq[i] != 32'h0 && seq[i] != 32'h13)
            exp_ret++;
      end
      for (int unsigned i = 0; i < 6; i++) begin
         wb_ir = seq[i];
         tick();
         if (i == 0) begin
            n_checks++; if (cycle_cnt !== 32'd1) begin n_errors++; $display("FAIL clr_resume_cnt got %0d exp 1", cycle_cnt); end
         end
      end
      wb_ir = 32'h0;
      issue(C_HALT, 16'd0);
      exp_cyc = 7;
`ifndef PIPE_RETIRE_CNT_EN
      exp_ret = 0;
`endif
      n_checks++; if (cycle_cnt !== exp_cyc) begin n_errors++; $display("FAIL clr_final_cnt got %0d exp %0d", cycle_cnt, exp_cyc); end
      n_checks++; if (retire_cnt !== exp_ret) begin n_errors++; $display("FAIL retire_cnt got %0d exp %0d", retire_cnt, exp_ret); end
   endtask

   task automatic test_reset_mid_step;
      issue(C_STEP, 16'd6);
      repeat (2) tick();
      rstn = 1'b0;
      #1;
      n_checks++; if (cpu_en !== 1'b0) begin n_errors++; $display("FAIL mid_rst_cpu_en got %b exp 0", cpu_en); end
      n_checks++; if (cycle_cnt !== 32'd0) begin n_errors++; $display("FAIL mid_rst_cnt got %0d exp 0", cycle_cnt); end
      n_checks++; if (cmd_ready !== 1'b1) begin n_errors++; $display("FAIL mid_rst_ready got %b exp 1", cmd_ready); end
      tick();
      rstn = 1'b1;
      for (int i = 0; i < 8; i++) begin
         tick();
         n_checks++; if (step_done !== 1'b0 || cpu_en !== 1'b0) begin n_errors++; $display("FAIL mid_rst_after got done=%b en=%b exp 0 0", step_done, cpu_en); end
      end
   endtask

   initial begin
      rstn = 1'b0; cmd_valid = 1'b0; cmd = 2'b00; step_n = 16'd0;
      bp_en = 1'b0; bp_addr = 32'hFFFF_FFF0; wb_ir = 32'h0;
      pc_load = 1'b0; pc_load_val = 32'h0;
      test_reset();
      test_run_halt();
      test_step(16'd3);
      test_step(16'd0);
      test_step(16'($urandom_range(1, 12)));
      test_breakpoint(7);
      test_breakpoint($urandom_range(1, 12));
      test_step_bp(5, 2);
      test_step_bp(4, 4);
      test_step_bp(9, $urandom_range(1, 8));
      test_clear();
      test_reset_mid_step();
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
